oled_spi_driver: RTL

- Downstream consumer of the image controller: streams each 128x64 SSD1306 frame (1024 bytes) over 4-wire SPI to the OLED panel.
- Owns the panel power-up reset and the init command sequence.
- Drives byte_counter into the image controller and samples the registered data_to_send that comes back.
- Sits between the image controller and the top-level OLED pins.

---
 rtl/oled_spi_driver.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/oled_spi_driver.sv
// SSD1306 4-wire SPI driver: power-up reset, init command ROM, frame stream.
// Ports: clk/rst (sync, active high); data_to_send in; byte_counter, oled_* pins, frame_done out.
module oled_spi_driver #(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned POWERUP_CYCLES = 250000,
  parameter int unsigned FRAME_BYTES    = 1024,
  parameter int unsigned BYTE_GAP       = 2,
  parameter int unsigned FRAME_GAP      = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_to_send,
  output logic [9:0] byte_counter,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_cs,
  output logic       oled_dc,
  output logic       oled_res,
  output logic       frame_done
);

  localparam int unsigned PW   = $clog2(POWERUP_CYCLES + 1);
  localparam int unsigned FW   = $clog2(FRAME_GAP + 1);
  localparam int unsigned WW   = (PW > FW) ? PW : FW;
  localparam int unsigned DW   = $clog2(CLK_DIV + 1);
  localparam int unsigned GW   = $clog2(BYTE_GAP + 1);
  localparam int unsigned NCMD = 31;

  typedef enum logic [2:0] {
    PWR_RES,
    PWR_WAIT,
    INIT,
    FETCH,
    SEND,
    GAP
  } state_t;

  state_t        r_state;
  logic [WW-1:0] r_wait;
  logic [DW-1:0] r_div;
  logic [GW-1:0] r_gcnt;
  logic          r_gap;
  logic [2:0]    r_bit;
  logic [6:0]    r_shift;
  logic [4:0]    r_rom;
  logic          r_fetch;

  logic       w_wait_end;
  logic       w_div_end;
  logic       w_gap_end;
  logic       w_start;
  logic [7:0] w_byte;

  function automatic logic [7:0] f_rom(input logic [4:0] i);
    unique case (i)
      5'd0:  return 8'hAE;
      5'd1:  return 8'hD5;
      5'd2:  return 8'h80;
      5'd3:  return 8'hA8;
      5'd4:  return 8'h3F;
      5'd5:  return 8'hD3;
      5'd6:  return 8'h00;
      5'd7:  return 8'h40;
      5'd8:  return 8'h8D;
      5'd9:  return 8'h14;
      5'd10: return 8'h20;
      5'd11: return 8'h00;
      5'd12: return 8'hA1;
      5'd13: return 8'hC8;
      5'd14: return 8'hDA;
      5'd15: return 8'h12;
      5'd16: return 8'h81;
      5'd17: return 8'hCF;
      5'd18: return 8'hD9;
      5'd19: return 8'hF1;
      5'd20: return 8'hDB;
      5'd21: return 8'h40;
      5'd22: return 8'hA4;
      5'd23: return 8'hA6;
      5'd24: return 8'h21;
      5'd25: return 8'h00;
      5'd26: return 8'h7F;
      5'd27: return 8'h22;
      5'd28: return 8'h00;
      5'd29: return 8'h07;
      5'd30: return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction

  assign w_wait_end = (r_wait == WW'(POWERUP_CYCLES - 1));
  assign w_div_end  = (r_div == DW'(CLK_DIV - 1));
  assign w_gap_end  = r_gap && (r_gcnt == GW'(BYTE_GAP - 1));

  // A byte starts on the same clk as the event that ends the previous
  // phase, so cs falls with bit7 already on sdin.
  assign w_start =
    ((r_state == PWR_WAIT) && w_wait_end) ||
    ((r_state == INIT) && w_gap_end && (r_rom != 5'(NCMD))) ||
    ((r_state == FETCH) && r_fetch);

  assign w_byte = (r_state == FETCH) ? data_to_send : f_rom(r_rom);

  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (rst) begin
      r_state      <= PWR_RES;
      r_wait       <= '0;
      r_div        <= '0;
      r_gcnt       <= '0;
      r_gap        <= 1'b0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_rom        <= '0;
      r_fetch      <= 1'b0;
      byte_counter <= '0;
      oled_sclk    <= 1'b0;
      oled_sdin    <= 1'b0;
      oled_cs      <= 1'b1;
      oled_dc      <= 1'b0;
      oled_res     <= 1'b0;
    end else begin
      unique case (r_state)
        PWR_RES: begin
          if (w_wait_end) begin
            r_wait   <= '0;
            oled_res <= 1'b1;
            r_state  <= PWR_WAIT;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        PWR_WAIT: begin
          if (w_wait_end) begin
            r_wait  <= '0;
            r_state <= INIT;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        INIT, SEND: begin
          if (!r_gap) begin
            if (w_div_end) begin
              r_div <= '0;
              if (!oled_sclk) begin
                oled_sclk <= 1'b1;
              end else begin
                oled_sclk <= 1'b0;
                oled_sdin <= r_shift[6];
                r_shift   <= {r_shift[5:0], 1'b0};
                r_bit     <= r_bit + 3'd1;
                if (r_bit == 3'd7) begin
                  oled_cs <= 1'b1;
                  r_gap   <= 1'b1;
                  r_gcnt  <= '0;
                end
              end
            end else begin
              r_div <= r_div + DW'(1);
            end
          end else if (!w_gap_end) begin
            r_gcnt <= r_gcnt + GW'(1);
          end else if (r_state == INIT) begin
            if (r_rom == 5'(NCMD)) begin
              r_state <= FETCH;
            end
          end else if (byte_counter == 10'(FRAME_BYTES - 1)) begin
            byte_counter <= '0;
            frame_done   <= 1'b1;
            r_wait       <= '0;
            r_state      <= GAP;
          end else begin
            byte_counter <= byte_counter + 10'd1;
            r_state      <= FETCH;
          end
        end
        FETCH: begin
          // 2nd clk: the registered pixel byte for byte_counter is valid
          if (!r_fetch) begin
            r_fetch <= 1'b1;
          end else begin
            r_fetch <= 1'b0;
            oled_dc <= 1'b1;
            r_state <= SEND;
          end
        end
        GAP: begin
          if (r_wait == WW'(FRAME_GAP - 1)) begin
            r_wait  <= '0;
            r_state <= FETCH;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        default: r_state <= PWR_RES;
      endcase

      if (w_start) begin
        r_shift   <= w_byte[6:0];
        oled_sdin <= w_byte[7];
        oled_cs   <= 1'b0;
        r_div     <= '0;
        r_bit     <= '0;
        r_gap     <= 1'b0;
        if (r_state != FETCH) begin
          r_rom <= r_rom + 5'd1;
        end
      end
    end
  end

endmodule
